div_sequencer: RTL
==================

# div_sequencer

Multi-cycle sequencer for the integer divide resource used by the ALU for DIV, DIVU, REM and REMU. It accepts the level start request and operands that the ALU core presents, and runs a radix-2 restoring division over 32 iterations. It handles sign correction, divide-by-zero and signed overflow, then returns the result with a single-cycle ready pulse that releases the ALU busy stall. It sits beside the ALU core in the execute stage and is aborted by pipeline flush.

## Interface
- `DATA_WIDTH`, default 32 (`CPU_WIDTH`): operand, quotient and remainder width. Iteration count equals `DATA_WIDTH`.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `div_start_i` in 1: level request from the ALU, sampled only in IDLE.
- `div_op_i` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Sampled with start.
- `dividend_i` in DATA_WIDTH: numerator, sampled with start.
- `divisor_i` in DATA_WIDTH: denominator, sampled with start.
- `flush_i` in 1: abort the current operation, return to IDLE, produce no result.
- `div_result_o` out DATA_WIDTH: quotient or remainder per the latched op. Registered.
- `div_res_ready_o` out 1: one-cycle pulse; `div_result_o` is valid in that cycle.
- `div_busy_o` out 1: high in CALC and DONE.

## Operation
- States are IDLE, CALC and DONE.
- IDLE:
  - If `flush_i` is high: stay in IDLE.
  - Otherwise, if `div_start_i` is high:
    - Latch the op and signs.
    - Latch the operand magnitudes: absolute value for DIV/REM when the MSB is set; raw value for DIVU/REMU.
    - Clear the 33-bit partial remainder and load the shift register with the dividend magnitude.
    - Count = 0.
    - If the divisor is 0, go to DONE directly with the special result; otherwise go to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left by one.
  - Compute trial = rem − divisor magnitude.
  - If trial ≥ 0: rem = trial and quotient LSB = 1; else quotient LSB = 0.
  - Count increments. After the iteration with count = DATA_WIDTH−1, go to DONE.
- DONE:
  - Drive `div_res_ready_o` = 1 and present `div_result_o`.
  - Next state is IDLE unconditionally.
- Sign correction, DIV/REM only:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Applied when loading the result register on the last CALC cycle.
- Divide by zero: quotient = all ones (0xFFFFFFFF) for DIV and DIVU; remainder = the unmodified dividend for REM and REMU.
- Signed overflow (DIV −2^31 / −1):
  - The magnitude path yields quotient 0x80000000 and remainder 0; the result must equal this.
  - No special state is needed.
- `flush_i` has priority over every other event in every state:
  - Next state is IDLE, and ready is not asserted in the following cycle.
  - `div_result_o` keeps its last value.
- The requester must drop `div_start_i`, or advance its instruction, in the cycle after ready is seen. A start still high in IDLE launches a new operation.

## Timing
- Reset values: state IDLE, `div_result_o` = 0, `div_res_ready_o` = 0, `div_busy_o` = 0, count = 0, internal registers 0.
- Normal latency:
  - Start high in cycle T (IDLE).
  - CALC runs in cycles T+1 .. T+32.
  - Ready is high in cycle T+33.
  - IDLE in T+34, where a new start can be accepted.
- Divide by zero: start in T, DONE/ready in T+1, IDLE in T+2.
- `div_busy_o` is high from T+1 through the ready cycle inclusive.
- Ready is exactly one cycle wide; it is never asserted twice per accepted start.
- `div_result_o` holds its value after the ready cycle until the next result load.
- Operand changes on the inputs during CALC have no effect.
- Reset asserted mid-operation forces the reset values asynchronously; no ready follows.

## Test plan
- DIVU 100 / 7, start in cycle T:
  - Ready only in T+33 with result 14.
  - Busy high in T+1..T+33.
  - Repeat as REMU: result 2.
- DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). REM 7 / −2 → 1.
- DIV and REM of any dividend (e.g. 0x12345678) by 0:
  - Ready in T+1.
  - DIV result 0xFFFFFFFF; REM result 0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Flush and reset aborts:
  - Start DIVU, assert `flush_i` in T+10: no ready pulse; IDLE and busy 0 in T+11.
  - A new DIVU 9 / 3 started in T+11 gives ready in T+44 with result 3.
  - Repeat the abort with `rst_n` low mid-CALC: all outputs 0 immediately.
- Back-to-back: hold start high across ready with new operands → the second operation starts in the IDLE cycle after ready and its ready comes 33 cycles later.

Source files
------------

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU/REM/REMU.
// Handles sign correction, divide-by-zero and flush aborts; ready is a one-cycle pulse.
module div_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  div_start_i,
   input  logic [1:0]            div_op_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   input  logic                  flush_i,
   output logic [DATA_WIDTH-1:0] div_result_o,
   output logic                  div_res_ready_o,
   output logic                  div_busy_o
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic                  quo_neg_q, quo_neg_d;
   logic                  rem_neg_q, rem_neg_d;
   logic [DATA_WIDTH-1:0] dsr_q, dsr_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH:0]   rem_q, rem_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;

   logic                  is_signed;
   logic [DATA_WIDTH-1:0] dvd_mag, dsr_mag;
   logic [DATA_WIDTH+1:0] shifted, trial;
   logic [DATA_WIDTH:0]   step_rem;
   logic [DATA_WIDTH-1:0] step_quo;
   logic [DATA_WIDTH-1:0] fin_quo, fin_rem, fin_result;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         dsr_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
      end else begin
         op_q      <= op_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         dsr_q     <= dsr_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
      end
   end

   // Next-state logic; flush overrides every transition
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (div_start_i) state_d = (divisor_i == '0) ? DONE : CALC;
            CALC:    if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // One restoring step; the extra top bit of shifted/trial carries the trial sign
   always_comb begin
      is_signed = ~div_op_i[0];
      dvd_mag   = (is_signed && dividend_i[DATA_WIDTH-1]) ? -dividend_i : dividend_i;
      dsr_mag   = (is_signed && divisor_i[DATA_WIDTH-1])  ? -divisor_i  : divisor_i;
      shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
      trial     = shifted - {2'b00, dsr_q};
      if (!trial[DATA_WIDTH+1]) begin
         step_rem = trial[DATA_WIDTH:0];
         step_quo = {quo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
         step_rem = shifted[DATA_WIDTH:0];
         step_quo = {quo_q[DATA_WIDTH-2:0], 1'b0};
      end
      fin_quo    = quo_neg_q ? -step_quo : step_quo;
      fin_rem    = rem_neg_q ? -step_rem[DATA_WIDTH-1:0] : step_rem[DATA_WIDTH-1:0];
      fin_result = op_q[1] ? fin_rem : fin_quo;
   end

   // Datapath next values
   always_comb begin
      op_d      = op_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      dsr_d     = dsr_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      if (!flush_i) begin
         unique case (state_q)
            IDLE: begin
               if (div_start_i) begin
                  op_d      = div_op_i;
                  quo_neg_d = is_signed && (dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1]);
                  rem_neg_d = is_signed && dividend_i[DATA_WIDTH-1];
                  dsr_d     = dsr_mag;
                  quo_d     = dvd_mag;
                  rem_d     = '0;
                  cnt_d     = '0;
                  if (divisor_i == '0) result_d = div_op_i[1] ? dividend_i : '1;
               end
            end
            CALC: begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) result_d = fin_result;
            end
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      div_result_o    = result_q;
      div_res_ready_o = (state_q == DONE);
      div_busy_o      = (state_q != IDLE);
   end

endmodule
